// File: rtl/layer_sram_responder.sv
// layer_sram_responder
// Bridges a wide pixel-block read/write request onto a narrow single-port
// SRAM. Each burst moves DATA_SIZE_WORDS words, one SRAM word per cycle,
// starting at the request address rounded down to a block boundary.
//
// Optional feature macro: ADDR_RANGE_CHECK_EN
//   defined   -> requests whose aligned base is >= 143360 are rejected with
//                a one-cycle err pulse and no SRAM access
//   undefined -> every address is accepted and err stays 0
//
// Ports
//   clk, n_rst      clock (rising edge), asynchronous active-low reset
//   read_enable     wide-block read request (accepted only when idle)
//   write_enable    wide-block write request (wins over a simultaneous read)
//   address         pixel-word address of the request
//   write_data      block to write, word k at [W*k +: W]
//   read_data       assembled read block, same word order
//   busy            burst in progress
//   rdata_valid     one-cycle pulse: read_data complete
//   wr_done         one-cycle pulse: write burst finished
//   err             one-cycle pulse: request rejected
//   sram_addr/re/we/wdata   narrow SRAM command side
//   sram_rdata      narrow SRAM read word, valid the cycle after sram_re
module layer_sram_responder #(
    parameter int unsigned ADDR_SIZE_BITS  = 24,
    parameter int unsigned WORD_SIZE_BYTES = 3,
    parameter int unsigned DATA_SIZE_WORDS = 64
) (
    input  logic                                           clk,
    input  logic                                           n_rst,
    input  logic                                           read_enable,
    input  logic                                           write_enable,
    input  logic [ADDR_SIZE_BITS-1:0]                      address,
    input  logic [WORD_SIZE_BYTES*8*DATA_SIZE_WORDS-1:0]   write_data,
    output logic [WORD_SIZE_BYTES*8*DATA_SIZE_WORDS-1:0]   read_data,
    output logic                                           busy,
    output logic                                           rdata_valid,
    output logic                                           wr_done,
    output logic                                           err,
    output logic [ADDR_SIZE_BITS-1:0]                      sram_addr,
    output logic                                           sram_re,
    output logic                                           sram_we,
    output logic [WORD_SIZE_BYTES*8-1:0]                   sram_wdata,
    input  logic [WORD_SIZE_BYTES*8-1:0]                   sram_rdata
);

    localparam int unsigned A   = ADDR_SIZE_BITS;
    localparam int unsigned W   = WORD_SIZE_BYTES * 8;
    localparam int unsigned B   = W * DATA_SIZE_WORDS;
    localparam int unsigned K_W = (DATA_SIZE_WORDS > 1) ? $clog2(DATA_SIZE_WORDS) : 1;

    localparam logic [K_W-1:0] K_LAST    = K_W'(DATA_SIZE_WORDS - 1);
    localparam logic [A-1:0]   BASE_MASK = ~A'((1 << K_W) - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD       = 2'd1,
        RD_DRAIN = 2'd2,
        WR       = 2'd3
    } state_t;

    state_t          r_state;
    logic [K_W-1:0]  r_k;
    logic [A-1:0]    r_base;
    logic [B-1:0]    r_wdata;
    logic [B-1:0]    r_rdata;
    logic            r_cap_en;
    logic [K_W-1:0]  r_cap_idx;
    logic            r_busy;
    logic            r_rdata_valid;
    logic            r_wr_done;
    logic            r_err;
    logic            r_sram_re;
    logic            r_sram_we;
    logic [A-1:0]    r_sram_addr;
    logic [W-1:0]    r_sram_wdata;

    logic [A-1:0]    w_base;
    logic [K_W-1:0]  w_k_next;
    logic [A-1:0]    w_addr_next;
    logic [W-1:0]    w_wdata_next;
    logic            w_addr_ok;

    // Block base: request address rounded down to a block boundary
    assign w_base      = address & BASE_MASK;
    assign w_k_next    = r_k + K_W'(1);
    assign w_addr_next = r_base + A'(w_k_next);

`ifdef ADDR_RANGE_CHECK_EN
    localparam longint unsigned ADDR_LIMIT = 64'd143360;
    assign w_addr_ok = (64'(w_base) < ADDR_LIMIT);
`else
    assign w_addr_ok = 1'b1;
`endif

    // Select the latched write word for the next burst position
    always_comb begin
        w_wdata_next = '0;
        for (int unsigned j = 0; j < DATA_SIZE_WORDS; j++) begin
            if (w_k_next == K_W'(j)) begin
                w_wdata_next = r_wdata[j*W +: W];
            end
        end
    end

    // Burst sequencer with registered SRAM strobes and completion pulses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_base        <= '0;
            r_wdata       <= '0;
            r_cap_en      <= 1'b0;
            r_cap_idx     <= '0;
            r_busy        <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_wr_done     <= 1'b0;
            r_err         <= 1'b0;
            r_sram_re     <= 1'b0;
            r_sram_we     <= 1'b0;
            r_sram_addr   <= '0;
            r_sram_wdata  <= '0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_wr_done     <= 1'b0;
            r_err         <= 1'b0;
            // A read strobe this cycle means its word arrives next cycle
            r_cap_en      <= r_sram_re;
            r_cap_idx     <= r_k;

            case (r_state)
                IDLE: begin
                    if (write_enable || read_enable) begin
                        if (!w_addr_ok) begin
                            r_err <= 1'b1;
                        end else if (write_enable) begin
                            r_state      <= WR;
                            r_busy       <= 1'b1;
                            r_base       <= w_base;
                            r_k          <= '0;
                            r_wdata      <= write_data;
                            r_sram_we    <= 1'b1;
                            r_sram_addr  <= w_base;
                            r_sram_wdata <= write_data[W-1:0];
                        end else begin
                            r_state      <= RD;
                            r_busy       <= 1'b1;
                            r_base       <= w_base;
                            r_k          <= '0;
                            r_sram_re    <= 1'b1;
                            r_sram_addr  <= w_base;
                        end
                    end
                end

                RD: begin
                    if (r_k == K_LAST) begin
                        r_state     <= RD_DRAIN;
                        r_k         <= '0;
                        r_sram_re   <= 1'b0;
                        r_sram_addr <= '0;
                    end else begin
                        r_k         <= w_k_next;
                        r_sram_addr <= w_addr_next;
                    end
                end

                // Waits for the last word, captured at this cycle's closing edge
                RD_DRAIN: begin
                    r_state       <= IDLE;
                    r_busy        <= 1'b0;
                    r_rdata_valid <= 1'b1;
                end

                WR: begin
                    if (r_k == K_LAST) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_k          <= '0;
                        r_wr_done    <= 1'b1;
                        r_sram_we    <= 1'b0;
                        r_sram_addr  <= '0;
                        r_sram_wdata <= '0;
                    end else begin
                        r_k          <= w_k_next;
                        r_sram_addr  <= w_addr_next;
                        r_sram_wdata <= w_wdata_next;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_k         <= '0;
                    r_sram_re   <= 1'b0;
                    r_sram_we   <= 1'b0;
                    r_sram_addr <= '0;
                end
            endcase
        end
    end

    // Read assembly: drop each returning word into its slot of the block
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rdata <= '0;
        end else if (r_cap_en) begin
            for (int unsigned j = 0; j < DATA_SIZE_WORDS; j++) begin
                if (r_cap_idx == K_W'(j)) begin
                    r_rdata[j*W +: W] <= sram_rdata;
                end
            end
        end
    end

    assign read_data   = r_rdata;
    assign busy        = r_busy;
    assign rdata_valid = r_rdata_valid;
    assign wr_done     = r_wr_done;
    assign err         = r_err;
    assign sram_addr   = r_sram_addr;
    assign sram_re     = r_sram_re;
    assign sram_we     = r_sram_we;
    assign sram_wdata  = r_sram_wdata;

endmodule

// File: tb/tb_layer_sram_responder.sv
// tb_layer_sram_responder
// Directed bench for layer_sram_responder: read, write, read/write collision,
// request during a burst, back-to-back request, address range handling and
// mid-burst reset. The SRAM model returns address + 0x100 one cycle after
// each read strobe.
module tb_layer_sram_responder;

    localparam int unsigned A = 24;
    localparam int unsigned W = 24;
    localparam int unsigned N = 64;
    localparam int unsigned B = W * N;

    logic          clk          = 1'b0;
    logic          n_rst        = 1'b0;
    logic          read_enable  = 1'b0;
    logic          write_enable = 1'b0;
    logic [A-1:0]  address      = '0;
    logic [B-1:0]  write_data   = '0;
    logic [B-1:0]  read_data;
    logic          busy;
    logic          rdata_valid;
    logic          wr_done;
    logic          err;
    logic [A-1:0]  sram_addr;
    logic          sram_re;
    logic          sram_we;
    logic [W-1:0]  sram_wdata;
    logic [W-1:0]  sram_rdata   = '0;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    layer_sram_responder #(
        .ADDR_SIZE_BITS  (24),
        .WORD_SIZE_BYTES (3),
        .DATA_SIZE_WORDS (64)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .busy         (busy),
        .rdata_valid  (rdata_valid),
        .wr_done      (wr_done),
        .err          (err),
        .sram_addr    (sram_addr),
        .sram_re      (sram_re),
        .sram_we      (sram_we),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model: data for the strobed address next cycle
    always @(posedge clk) begin
        if (sram_re) sram_rdata <= sram_addr + 24'h000100;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after the accepting edge; ends in the rdata_valid cycle
    task automatic chk_rd_burst(input logic [A-1:0] base, input int inj);
        for (int k = 0; k < int'(N); k++) begin
            chk1("rd_re", sram_re, 1'b1);
            chk1("rd_we", sram_we, 1'b0);
            chk1("rd_busy", busy, 1'b1);
            chk1("rd_valid_early", rdata_valid, 1'b0);
            chk("rd_addr", 64'(sram_addr), 64'(A'(base + A'(k))));
            if (k == inj) begin
                write_enable = 1'b1;
                address      = 24'h001234;
            end else begin
                write_enable = 1'b0;
                read_enable  = 1'b0;
            end
            tick();
        end
        chk1("drain_re", sram_re, 1'b0);
        chk1("drain_busy", busy, 1'b1);
        chk1("drain_valid", rdata_valid, 1'b0);
        tick();
        chk1("rd_valid", rdata_valid, 1'b1);
        chk1("rd_idle_busy", busy, 1'b0);
        chk1("rd_idle_re", sram_re, 1'b0);
        chk("rd_idle_addr", 64'(sram_addr), 64'd0);
        for (int k = 0; k < int'(N); k++) begin
            chk("rd_word", 64'(read_data[k*W +: W]), 64'(W'(base + A'(k) + 24'h000100)));
        end
    endtask

    // Called 1 time unit after the accepting edge; ends one cycle after wr_done
    task automatic chk_wr_burst(input logic [A-1:0] base, input logic [W-1:0] pat);
        for (int k = 0; k < int'(N); k++) begin
            chk1("wr_we", sram_we, 1'b1);
            chk1("wr_re", sram_re, 1'b0);
            chk1("wr_busy", busy, 1'b1);
            chk1("wr_valid", rdata_valid, 1'b0);
            chk("wr_addr", 64'(sram_addr), 64'(A'(base + A'(k))));
            chk("wr_wdata", 64'(sram_wdata), 64'(W'(pat + W'(k))));
            tick();
        end
        chk1("wr_done", wr_done, 1'b1);
        chk1("wr_idle_busy", busy, 1'b0);
        chk1("wr_idle_we", sram_we, 1'b0);
        chk1("wr_no_rvalid", rdata_valid, 1'b0);
        chk("wr_idle_addr", 64'(sram_addr), 64'd0);
        tick();
        chk1("wr_done_drop", wr_done, 1'b0);
        chk1("wr_no_rvalid2", rdata_valid, 1'b0);
        chk1("wr_stay_idle", busy, 1'b0);
    endtask

    logic [B-1:0] saved;
    int           n_strobe;
    int           n_pulse;
    int           n_busy;

    initial begin
        // Reset state
        tick();
        tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rvalid", rdata_valid, 1'b0);
        chk1("rst_wr_done", wr_done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_re", sram_re, 1'b0);
        chk1("rst_we", sram_we, 1'b0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_wdata", 64'(sram_wdata), 64'd0);
        chk1("rst_rdata", read_data === '0, 1'b1);
        n_rst = 1'b1;
        tick();
        chk1("idle_busy", busy, 1'b0);

        // Read at address 0
        address     = 24'h000000;
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        chk_rd_burst(24'h000000, -1);

        // Back-to-back read in the rdata_valid cycle, with a write poked at cycle 10
        address     = 24'h000805;
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        chk_rd_burst(24'h000800, 10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("post_busy", busy, 1'b0);
            chk1("post_we", sram_we, 1'b0);
            chk1("post_rvalid", rdata_valid, 1'b0);
        end
        chk("rd_hold", 64'(read_data[5*W +: W]), 64'h000905);

        // Write at 65536; input data changes after acceptance
        for (int k = 0; k < int'(N); k++) write_data[k*W +: W] = W'(24'hABC000 + W'(k));
        address      = 24'd65536;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        write_data   = '1;
        chk_wr_burst(24'd65536, 24'hABC000);

        // Read and write together: write wins, read is dropped
        saved = read_data;
        for (int k = 0; k < int'(N); k++) write_data[k*W +: W] = W'(24'h5A0000 + W'(k));
        address      = 24'd70;
        read_enable  = 1'b1;
        write_enable = 1'b1;
        tick();
        read_enable  = 1'b0;
        write_enable = 1'b0;
        chk_wr_burst(24'd64, 24'h5A0000);
        chk1("coll_rdata_kept", read_data === saved, 1'b1);

`ifdef ADDR_RANGE_CHECK_EN
        // Out-of-range request is rejected
        saved       = read_data;
        address     = 24'd143360;
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        chk1("range_err", err, 1'b1);
        chk1("range_busy", busy, 1'b0);
        chk1("range_re", sram_re, 1'b0);
        tick();
        chk1("range_err_drop", err, 1'b0);
        chk1("range_busy2", busy, 1'b0);
        chk1("range_re2", sram_re, 1'b0);
        chk1("range_rdata_kept", read_data === saved, 1'b1);
        // Last in-range block completes
        address     = 24'd143296;
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        chk1("inrange_err", err, 1'b0);
        chk_rd_burst(24'd143296, -1);
`else
        // Without range checking every address is served
        address     = 24'd143360;
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        chk1("norange_err", err, 1'b0);
        chk_rd_burst(24'd143360, -1);
        // Top block: model data wraps past 2^24
        address     = 24'hFFFFFF;
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        chk1("top_err", err, 1'b0);
        chk_rd_burst(24'hFFFFC0, -1);
`endif

        // Reset in the middle of a read burst
        tick();
        address     = 24'h000400;
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("mid_addr", 64'(sram_addr), 64'h00041E);
        n_rst = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_re", sram_re, 1'b0);
        chk1("abort_we", sram_we, 1'b0);
        chk1("abort_rvalid", rdata_valid, 1'b0);
        chk1("abort_wr_done", wr_done, 1'b0);
        chk1("abort_err", err, 1'b0);
        chk("abort_addr", 64'(sram_addr), 64'd0);
        chk("abort_wdata", 64'(sram_wdata), 64'd0);
        chk1("abort_rdata", read_data === '0, 1'b1);
        tick();
        n_rst    = 1'b1;
        n_strobe = 0;
        n_pulse  = 0;
        n_busy   = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (sram_re || sram_we) n_strobe++;
            if (rdata_valid || wr_done || err) n_pulse++;
            if (busy) n_busy++;
        end
        chk("post_rst_strobes", 64'(n_strobe), 64'd0);
        chk("post_rst_pulses", 64'(n_pulse), 64'd0);
        chk("post_rst_busy", 64'(n_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
